// File: rtl/bcd2bin_serial.sv
// -----------------------------------------------------------------------------
// bcd2bin_serial
//
// Sequential packed-BCD to binary converter using reverse double-dabble.
// It performs one iteration per clock: the {bcd, bin} pair is shifted right
// by one bit, then every BCD digit of the shifted value that is >= 8 has 3
// subtracted. After BIN_W iterations the binary register holds the result and
// the BCD register has drained to zero. This is the inverse of the
// combinational binary-to-BCD block. It is used to turn packed BCD time/date
// fields back into binary counter values.
//
// Parameters
//   DIGITS  number of packed BCD digits on bcd_in (>= 1)
//   BIN_W   result width and iteration count; 2**BIN_W must exceed
//           10**DIGITS - 1 (7 for two digits, 14 for four digits)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset; aborts any conversion in flight
//   start    conversion request, accepted only while ready is high
//   bcd_in   packed BCD operand, digit 0 in [3:0]; sampled on the accepting edge
//   ready    high while idle (decoded from state)
//   valid    one-cycle pulse marking an update of bin_out / err
//   bin_out  converted binary value, held until the next valid
//   err      set with valid when any input nibble was above 9 (bin_out is 0)
// -----------------------------------------------------------------------------
module bcd2bin_serial #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  valid,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BCD_W-1:0]        bcd_r;
    logic [BIN_W-1:0]        bin_r;
    logic [CNT_W-1:0]        cnt;
    logic                    err_pend;

    logic [BCD_W+BIN_W-1:0]  pair_shift;
    logic [BCD_W-1:0]        bcd_shift;
    logic [BCD_W-1:0]        bcd_corr;
    logic [BIN_W-1:0]        bin_shift;
    logic                    accept;
    logic                    last_iter;

    // Undo one step of the forward "add 3 if >= 5": a digit whose MSB was
    // just filled by the neighbour's LSB is worth 5 there, not 8.
    // Four-bit modulo arithmetic, so 8..15 map to 5..12.
    function automatic logic [3:0] dabble_down(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d >= 4'd8) begin
            r = d - 4'd3;
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = dabble_down(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic any_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One reverse double-dabble iteration: the BCD LSB drops into the binary
    // MSB, then the shifted BCD digits are corrected combinationally.
    assign pair_shift = {bcd_r, bin_r} >> 1;
    assign bcd_shift  = pair_shift[BCD_W+BIN_W-1:BIN_W];
    assign bin_shift  = pair_shift[BIN_W-1:0];
    assign bcd_corr   = correct_digits(bcd_shift);

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == CONV) && (cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ready = (state == IDLE);
    end

    // Iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r    <= '0;
            bin_r    <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            bin_out  <= '0;
            err      <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                bcd_r    <= bcd_in;
                bin_r    <= '0;
                cnt      <= '0;
                err_pend <= any_bad_digit(bcd_in);
            end else if (state == CONV) begin
                bcd_r <= bcd_corr;
                bin_r <= bin_shift;
                cnt   <= cnt + 1'b1;
                // The final shift completes the result; publish it directly
                // from the shifted value rather than waiting a cycle.
                if (last_iter) begin
                    bin_out <= err_pend ? '0 : bin_shift;
                    err     <= err_pend;
                    valid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin_serial.sv
module tb_bcd2bin_serial;

    logic        clk = 1'b0;
    logic        rst;

    logic        start2;
    logic [7:0]  bcd2;
    logic        ready2;
    logic        valid2;
    logic [6:0]  bin2;
    logic        err2;

    logic        start4;
    logic [15:0] bcd4;
    logic        ready4;
    logic        valid4;
    logic [13:0] bin4;
    logic        err4;

    int checks = 0;
    int errors = 0;

    // Scoreboards: {err, bin} pushed at stimulus, popped at valid.
    logic [7:0]  q2[$];
    logic [14:0] q4[$];

    always #5 clk = ~clk;

    bcd2bin_serial #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .bcd_in  (bcd2),
        .ready   (ready2),
        .valid   (valid2),
        .bin_out (bin2),
        .err     (err2)
    );

    bcd2bin_serial #(.DIGITS(4), .BIN_W(14)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start4),
        .bcd_in  (bcd4),
        .ready   (ready4),
        .valid   (valid4),
        .bin_out (bin4),
        .err     (err4)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Decimal reference: weighted digit sum, err if any nibble > 9.
    function automatic logic [14:0] model(input logic [15:0] b, input int nd);
        int v;
        int w;
        logic bad;
        logic [3:0] d;
        v = 0;
        w = 1;
        bad = 1'b0;
        for (int i = 0; i < nd; i++) begin
            d = b[4*i +: 4];
            if (d > 4'd9) bad = 1'b1;
            v = v + int'(d) * w;
            w = w * 10;
        end
        if (bad) v = 0;
        return {bad, 14'(v)};
    endfunction

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic run2(input logic [7:0] b, input int exp_bin, input logic exp_err);
        int n;
        logic [7:0] e;
        q2.push_back({exp_err, 7'(exp_bin)});
        checks++;
        if (ready2 !== 1'b1) begin
            errors++;
            $display("FAIL d2_ready_idle bcd=%h got %b want 1", b, ready2);
        end
        start2 = 1'b1;
        bcd2   = b;
        tick;
        start2 = 1'b0;
        bcd2   = ~b;
        checks++;
        if (ready2 !== 1'b0) begin
            errors++;
            $display("FAIL d2_ready_busy bcd=%h got %b want 0", b, ready2);
        end
        n = 0;
        while (valid2 !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (valid2 !== 1'b1) begin
            errors++;
            $display("FAIL d2_timeout bcd=%h got no valid want valid", b);
            void'(q2.pop_front());
            return;
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL d2_latency bcd=%h got %0d want 7", b, n);
        end
        e = q2.pop_front();
        checks++;
        if (bin2 !== e[6:0]) begin
            errors++;
            $display("FAIL d2_bin bcd=%h got %0d want %0d", b, bin2, e[6:0]);
        end
        checks++;
        if (err2 !== e[7]) begin
            errors++;
            $display("FAIL d2_err bcd=%h got %b want %b", b, err2, e[7]);
        end
        tick;
        checks++;
        if (valid2 !== 1'b0) begin
            errors++;
            $display("FAIL d2_valid_pulse bcd=%h got %b want 0", b, valid2);
        end
    endtask

    task automatic run4(input logic [15:0] b, input logic [14:0] exp);
        int n;
        logic [14:0] e;
        q4.push_back(exp);
        start4 = 1'b1;
        bcd4   = b;
        tick;
        start4 = 1'b0;
        bcd4   = ~b;
        checks++;
        if (ready4 !== 1'b0) begin
            errors++;
            $display("FAIL d4_ready_busy bcd=%h got %b want 0", b, ready4);
        end
        n = 0;
        while (valid4 !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        checks++;
        if (valid4 !== 1'b1) begin
            errors++;
            $display("FAIL d4_timeout bcd=%h got no valid want valid", b);
            void'(q4.pop_front());
            return;
        end
        e = q4.pop_front();
        checks++;
        if (n != 14 || bin4 !== e[13:0] || err4 !== e[14]) begin
            errors++;
            $display("FAIL d4_result bcd=%h got lat=%0d bin=%0d err=%b want lat=14 bin=%0d err=%b",
                     b, n, bin4, err4, e[13:0], e[14]);
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        bcd2 = 8'h00;
        bcd4 = 16'h0000;
        tick;
        tick;
        rst = 1'b0;
        checks++;
        if (ready2 !== 1'b1 || valid2 !== 1'b0 || bin2 !== 7'd0 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_d2 got ready=%b valid=%b bin=%0d err=%b want 1 0 0 0",
                     ready2, valid2, bin2, err2);
        end
        checks++;
        if (ready4 !== 1'b1 || valid4 !== 1'b0 || bin4 !== 14'd0 || err4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_d4 got ready=%b valid=%b bin=%0d err=%b want 1 0 0 0",
                     ready4, valid4, bin4, err4);
        end
    endtask

    task automatic test_basic;
        run2(8'h59, 59, 1'b0);
        run2(8'h99, 99, 1'b0);
        run2(8'h00, 0, 1'b0);
        run2(8'h10, 10, 1'b0);
    endtask

    task automatic test_invalid;
        run2(8'h4A, 0, 1'b1);
        run2(8'h23, 23, 1'b0);
        run2(8'hF0, 0, 1'b1);
    endtask

    task automatic test_busy;
        int nv;
        int at;
        logic [7:0] e;
        nv = 0;
        at = -1;
        q2.push_back({1'b0, 7'd45});
        start2 = 1'b1;
        bcd2 = 8'h45;
        tick;
        for (int i = 1; i <= 20; i++) begin
            start2 = (i == 2 || i == 5);
            bcd2 = (i == 2 || i == 5) ? 8'h12 : 8'h77;
            tick;
            if (i < 7) begin
                checks++;
                if (ready2 !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready cycle=%0d got %b want 0", i, ready2);
                end
            end
            if (valid2 === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    at = i;
                    e = q2.pop_front();
                    checks++;
                    if (bin2 !== e[6:0] || err2 !== e[7]) begin
                        errors++;
                        $display("FAIL busy_result got bin=%0d err=%b want bin=%0d err=%b",
                                 bin2, err2, e[6:0], e[7]);
                    end
                end
            end
        end
        start2 = 1'b0;
        checks++;
        if (nv != 1 || at != 7) begin
            errors++;
            $display("FAIL busy_valid_count got count=%0d at=%0d want count=1 at=7", nv, at);
        end
    endtask

    task automatic test_back_to_back;
        int nv;
        int first;
        int second;
        logic drop;
        logic [7:0] e;
        nv = 0;
        first = -1;
        second = -1;
        drop = 1'b0;
        q2.push_back({1'b0, 7'd31});
        q2.push_back({1'b0, 7'd7});
        start2 = 1'b1;
        bcd2 = 8'h31;
        tick;
        for (int i = 1; i <= 30; i++) begin
            tick;
            if (drop) begin
                drop = 1'b0;
                start2 = 1'b0;
                bcd2 = 8'h55;
                checks++;
                if (ready2 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept got ready=%b want 0", ready2);
                end
            end
            if (valid2 === 1'b1) begin
                nv++;
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    checks++;
                    if (bin2 !== e[6:0] || err2 !== e[7]) begin
                        errors++;
                        $display("FAIL b2b_result n=%0d got bin=%0d err=%b want bin=%0d err=%b",
                                 nv, bin2, err2, e[6:0], e[7]);
                    end
                end
                if (nv == 1) begin
                    first = i;
                    checks++;
                    if (ready2 !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_ready_at_valid got %b want 1", ready2);
                    end
                    bcd2 = 8'h07;
                    drop = 1'b1;
                end else if (nv == 2) begin
                    second = i;
                end
            end
        end
        start2 = 1'b0;
        checks++;
        if (nv != 2 || (second - first) != 8) begin
            errors++;
            $display("FAIL b2b_spacing got count=%0d gap=%0d want count=2 gap=8",
                     nv, second - first);
        end
    endtask

    task automatic test_reset_midop;
        int nv;
        nv = 0;
        start2 = 1'b1;
        bcd2 = 8'h88;
        tick;
        start2 = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (valid2 !== 1'b0 || bin2 !== 7'd0 || err2 !== 1'b0 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset got valid=%b bin=%0d err=%b ready=%b want 0 0 0 1",
                     valid2, bin2, err2, ready2);
        end
        for (int i = 0; i < 20; i++) begin
            tick;
            if (valid2 === 1'b1) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL midop_no_valid got %0d want 0", nv);
        end
        run2(8'h88, 88, 1'b0);
    endtask

    task automatic test_sweep_d2;
        logic [14:0] m;
        for (int v = 0; v < 256; v++) begin
            m = model(16'(v), 2);
            run2(8'(v), int'(m[6:0]), m[14]);
        end
    endtask

    task automatic test_d4;
        logic [15:0] b;
        run4(16'h9999, {1'b0, 14'd9999});
        run4(16'h2024, {1'b0, 14'd2024});
        run4(16'h0000, {1'b0, 14'd0});
        run4(16'h12A4, {1'b1, 14'd0});
        for (int v = 0; v <= 9999; v += 7) begin
            b = to_bcd4(v);
            run4(b, model(b, 4));
        end
        for (int k = 0; k < 100; k++) begin
            b = 16'($urandom);
            run4(b, model(b, 4));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_invalid;
        test_busy;
        test_back_to_back;
        test_reset_midop;
        test_sweep_d2;
        test_d4;
        checks++;
        if (q2.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got q2=%0d q4=%0d want 0 0", q2.size(), q4.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
